// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// funct3 encodings, FSM state type and iteration count.
package muldiv_pkg;

    localparam int ITER = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_abs.sv
// 32-bit conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of results.
module muldiv_abs (
    input  logic [31:0] value,
    input  logic        neg,
    output logic [31:0] result
);

    assign result = neg ? (~value + 32'd1) : value;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage (32 cycles per op).
// Optional MULDIV_EARLY_OUT_EN: trivial operands finish at the accept edge.
//
// state | meaning
// IDLE  | no operation in flight
// RUN   | one shift-add / shift-subtract iteration per edge
// DONE  | result_o valid for one cycle (done_o), may accept back-to-back
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_addr_o
);

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [63:0] work_q, work_d;
    logic [31:0] opb_q;
    logic        neg_a_q, neg_b_q;
    logic [5:0]  cnt_q;
    logic [4:0]  rd_q, rd_out_q;
    logic [31:0] result_q;

    logic        is_div_in, sgn1_in, sgn2_in, a_neg_in, b_neg_in;
    logic [31:0] a_mag, b_mag;
    logic        accept, last_iter;
    logic        early_hit;
    logic [31:0] early_res;

    assign is_div_in = op_i[2];
    assign sgn1_in   = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                       (op_i == OP_DIV)  || (op_i == OP_REM);
    assign sgn2_in   = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign a_neg_in  = sgn1_in & rs1_data_i[31];
    assign b_neg_in  = sgn2_in & rs2_data_i[31];

    muldiv_abs u_abs_a (.value(rs1_data_i), .neg(a_neg_in), .result(a_mag));
    muldiv_abs u_abs_b (.value(rs2_data_i), .neg(b_neg_in), .result(b_mag));

    assign accept    = valid_i && !flush_i && (state_q != RUN);
    assign last_iter = (state_q == RUN) && (cnt_q == 6'(ITER - 1));

`ifdef MULDIV_EARLY_OUT_EN
    logic div_zero_in, ovf_in;
    assign div_zero_in = is_div_in && (rs2_data_i == 32'd0);
    assign ovf_in      = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                         (rs1_data_i == 32'h8000_0000) && (rs2_data_i == 32'hFFFF_FFFF);
    assign early_hit   = div_zero_in || ovf_in ||
                         (!is_div_in && ((rs1_data_i == 32'd0) || (rs2_data_i == 32'd0)));
    always_comb begin
        early_res = 32'd0;
        if (div_zero_in)
            early_res = op_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
        else if (ovf_in)
            early_res = op_i[1] ? 32'd0 : 32'h8000_0000;
    end
`else
    assign early_hit = 1'b0;
    assign early_res = 32'd0;
`endif

    // Shared 64-bit work register: {hi, multiplier} for MUL, {remainder, quotient} for DIV.
    logic [32:0] mul_sum, div_shift, div_trial;
    always_comb begin
        mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
        div_shift = {work_q[63:32], work_q[31]};
        div_trial = div_shift - {1'b0, opb_q};
        if (!op_q[2])
            work_d = {mul_sum, work_q[31:1]};
        else if (!div_trial[32])
            work_d = {div_trial[31:0], work_q[30:0], 1'b1};
        else
            work_d = {div_shift[31:0], work_q[30:0], 1'b0};
    end

    logic        sgn_ab, hi_neg, div_zero_q;
    logic [31:0] lo_fixed, hi_fixed, res_full;

    assign sgn_ab     = neg_a_q ^ neg_b_q;
    assign hi_neg     = op_q[2] ? neg_a_q : sgn_ab;
    assign div_zero_q = (opb_q == 32'd0);

    muldiv_abs u_fix_lo (.value(work_d[31:0]),  .neg(sgn_ab), .result(lo_fixed));
    muldiv_abs u_fix_hi (.value(work_d[63:32]), .neg(hi_neg), .result(hi_fixed));

    // High half of a negated 64-bit product only takes the +1 carry when the low half is zero.
    always_comb begin
        res_full = 32'd0;
        case (op_q)
            OP_MUL:                        res_full = lo_fixed;
            OP_MULH, OP_MULHSU, OP_MULHU:  res_full = (sgn_ab && (work_d[31:0] != 32'd0)) ?
                                                      ~work_d[63:32] : hi_fixed;
            OP_DIV, OP_DIVU:               res_full = div_zero_q ? 32'hFFFF_FFFF : lo_fixed;
            default:                       res_full = hi_fixed;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept)
                    state_d = early_hit ? DONE : RUN;
                else
                    state_d = IDLE;
            end
            RUN: begin
                if (last_iter)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= 3'd0;
            work_q   <= 64'd0;
            opb_q    <= 32'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cnt_q    <= 6'd0;
            rd_q     <= 5'd0;
            rd_out_q <= 5'd0;
            result_q <= 32'd0;
        end else if (accept) begin
            op_q    <= op_i;
            neg_a_q <= a_neg_in;
            neg_b_q <= b_neg_in;
            rd_q    <= rd_addr_i;
            cnt_q   <= 6'd0;
            work_q  <= is_div_in ? {32'd0, a_mag} : {32'd0, b_mag};
            opb_q   <= is_div_in ? b_mag : a_mag;
            if (early_hit) begin
                result_q <= early_res;
                rd_out_q <= rd_addr_i;
            end
        end else if ((state_q == RUN) && !flush_i) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 6'd1;
            if (last_iter) begin
                result_q <= res_full;
                rd_out_q <= rd_q;
            end
        end
    end

    assign busy_o    = (state_q == RUN);
    assign done_o    = (state_q == DONE);
    assign result_o  = result_q;
    assign rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: driver pushes expected results, monitor
// pops on done_o. Honours MULDIV_EARLY_OUT_EN for latency expectations.
module tb_ex_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] rs1_data_i = 32'd0;
    logic [31:0] rs2_data_i = 32'd0;
    logic [4:0]  rd_addr_i = 5'd0;
    logic        flush_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    ex_muldiv dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .op_i(op_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .rd_addr_o(rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          busy;
        int          acc;
        int          gap;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = 32'd0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Latency counts the accept edge itself as cycle 1, so done in the
    // cycle right after the accept edge reads as 1.
    int busy_run = 0;
    int last_done = 0;
    always @(negedge clk_i) begin
        if (done_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 expected no done (result 0x%08h)", result_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", result_o, e.res);
                chk("rd_addr", 32'(rd_addr_o), 32'(e.rd));
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                chk("busy_cycles", 32'(busy_run), 32'(e.busy));
                if (e.gap != 0)
                    chk("done_gap", 32'(cyc - last_done), 32'(e.gap));
            end
            last_done = cyc;
            busy_run = 0;
        end else if (busy_o) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input bit early,
                         input bit push, input int gap);
        exp_t e;
        op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        if (push) begin
            e.res = res; e.rd = rd; e.acc = cyc; e.gap = gap;
`ifdef MULDIV_EARLY_OUT_EN
            e.lat  = early ? 1 : 33;
            e.busy = early ? 0 : 32;
`else
            e.lat  = 33;
            e.busy = 32;
`endif
            exp_q.push_back(e);
            last_res = res;
        end
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk_i); #1;
        end
        checks++;
        errors++;
        $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
        exp_q.delete();
    endtask

    task automatic wait_done_high();
        for (int i = 0; i < 200; i++) begin
            if (done_o) return;
            @(posedge clk_i); #1;
        end
        checks++;
        errors++;
        $display("FAIL timeout_done: got done_o=0 expected done_o=1");
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input bit early);
        issue(op, a, b, rd, res, early, 1'b1, 0);
        wait_empty();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_rd", 32'(rd_addr_o), 32'd0);

        // MUL with valid_i pulsed while running: must be ignored.
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 1'b1, 0);
        repeat (3) @(posedge clk_i);
        #1;
        op_i = 3'b101; rs1_data_i = 32'd1; rs2_data_i = 32'd1; rd_addr_i = 5'd31; valid_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        wait_empty();

        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 1'b0);
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 1'b0);
        run(3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 1'b0);
        run(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000, 1'b0);
        run(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 1'b0);
        run(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 1'b0);
        run(3'b100, 32'd20,        32'hFFFF_FFFA, 5'd12, 32'hFFFF_FFFD, 1'b0);
        run(3'b110, 32'd20,        32'hFFFF_FFFA, 5'd13, 32'd2,         1'b0);
        run(3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1'b1);
        run(3'b110, 32'd5,         32'd0,         5'd15, 32'd5,         1'b1);
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1'b1);
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1'b1);
        run(3'b000, 32'd0,         32'h0001_2345, 5'd18, 32'd0,         1'b1);

        // Flush at iteration 10, held one more edge with valid_i to show flush wins.
        issue(3'b101, 32'd1000, 32'd3, 5'd19, 32'd0, 1'b0, 1'b0, 0);
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1; valid_i = 1'b1;
        @(posedge clk_i); #1;
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_done", 32'(done_o), 32'd0);
        chk("flush_result", result_o, last_res);
        @(posedge clk_i); #1;
        chk("flush_valid_busy", 32'(busy_o), 32'd0);
        flush_i = 1'b0; valid_i = 1'b0;
        repeat (40) @(posedge clk_i);
        #1;
        chk("flush_result_hold", result_o, last_res);
        run(3'b101, 32'd100, 32'd7, 5'd20, 32'd14, 1'b0);
        run(3'b111, 32'd100, 32'd7, 5'd21, 32'd2,  1'b0);

        // Reset mid-run discards the operation.
        issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd22, 32'd0, 1'b0, 1'b0, 0);
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_rd", 32'(rd_addr_o), 32'd0);
        repeat (40) @(posedge clk_i);
        #1;

        // Back-to-back: second accept during the first DONE cycle.
        issue(3'b000, 32'd6, 32'd7, 5'd23, 32'd42, 1'b0, 1'b1, 0);
        wait_done_high();
        issue(3'b101, 32'd81, 32'd9, 5'd24, 32'd9, 1'b0, 1'b1, 33);
        wait_empty();

        repeat (3) @(posedge clk_i);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
